// File: rtl/nios_sys_led_driver_pkg.sv
// Shared constants for the LED driver: register map, CTRL bit positions
// and the values the configuration registers take on reset.
package nios_sys_led_driver_pkg;

  localparam logic [1:0] ADDR_CTRL       = 2'd0;
  localparam logic [1:0] ADDR_DUTY       = 2'd1;
  localparam logic [1:0] ADDR_BLINK_MASK = 2'd2;
  localparam logic [1:0] ADDR_BLINK_DIV  = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  localparam logic [7:0]  PWM_FULL        = 8'hFF;
  localparam logic [1:0]  CTRL_RESET      = 2'b01;
  localparam logic [7:0]  DUTY_RESET      = 8'hFF;
  localparam logic [15:0] BLINK_DIV_RESET = 16'h0000;

endpackage

// File: rtl/nios_sys_led_timebase.sv
// Timebase for the LED driver: prescaler, 256-step PWM frame counter and
// the blink half-period counter/phase that advances once per frame.
module nios_sys_led_timebase
  import nios_sys_led_driver_pkg::*;
#(
  parameter int PRESCALE_DIV = 196
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] blink_div_i,
  input  logic        blink_div_wr_i,
  output logic        tick_o,
  output logic [7:0]  pwm_cnt_o,
  output logic        frame_end_o,
  output logic        blink_phase_o
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic        tick;
  logic        frame_end;

  assign tick      = (presc_q == PRESCALE_LAST);
  assign frame_end = tick && (pwm_cnt_q == PWM_FULL);

  always_comb begin
    presc_d       = tick ? 16'd0 : presc_q + 16'd1;
    pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    // A divider write restarts the blink cycle and wins over a coincident frame_end
    if (blink_div_wr_i || (blink_div_i == 16'd0)) begin
      blink_cnt_d   = 16'd0;
      blink_phase_d = 1'b1;
    end else if (frame_end) begin
      if (blink_cnt_q == blink_div_i - 16'd1) begin
        blink_cnt_d   = 16'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q       <= 16'd0;
      pwm_cnt_q     <= 8'd0;
      blink_cnt_q   <= 16'd0;
      blink_phase_q <= 1'b1;
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign tick_o        = tick;
  assign pwm_cnt_o     = pwm_cnt_q;
  assign frame_end_o   = frame_end;
  assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/nios_sys_led_driver.sv
// LED pin driver behind the PIO: Avalon-MM config registers, frame-shadowed
// PWM duty, per-LED blink masking, enable and polarity on a registered output.
module nios_sys_led_driver
  import nios_sys_led_driver_pkg::*;
#(
  parameter int PRESCALE_DIV = 196,
  parameter int LED_W        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [LED_W-1:0] led_in,
  output logic [LED_W-1:0] led_out
);

  logic [1:0]       ctrl_q, ctrl_d;
  logic [7:0]       duty_q, duty_d;
  logic [7:0]       duty_act_q, duty_act_d;
  logic [LED_W-1:0] blink_mask_q, blink_mask_d;
  logic [15:0]      blink_div_q, blink_div_d;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_out_q, led_out_d;

  logic       wr;
  logic       blink_div_wr;
  logic       tick_unused;
  logic [7:0] pwm_cnt;
  logic       frame_end;
  logic       blink_phase;
  logic       pwm_on;
  logic       unused_bits;

  assign wr           = chipselect && !write_n;
  assign blink_div_wr = wr && (address == ADDR_BLINK_DIV);
  assign unused_bits  = ^{writedata[31:16], tick_unused};

  nios_sys_led_timebase #(
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_timebase (
    .clk            (clk),
    .reset_n        (reset_n),
    .blink_div_i    (blink_div_q),
    .blink_div_wr_i (blink_div_wr),
    .tick_o         (tick_unused),
    .pwm_cnt_o      (pwm_cnt),
    .frame_end_o    (frame_end),
    .blink_phase_o  (blink_phase)
  );

  always_comb begin
    ctrl_d       = ctrl_q;
    duty_d       = duty_q;
    blink_mask_d = blink_mask_q;
    blink_div_d  = blink_div_q;
    if (wr) begin
      case (address)
        ADDR_CTRL:       ctrl_d       = writedata[1:0];
        ADDR_DUTY:       duty_d       = writedata[7:0];
        ADDR_BLINK_MASK: blink_mask_d = writedata[LED_W-1:0];
        default:         blink_div_d  = writedata[15:0];
      endcase
    end
    // Active duty only changes at a frame boundary; duty_d already holds a same-cycle write
    duty_act_d = frame_end ? duty_d : duty_act_q;
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:       readdata[1:0]       = ctrl_q;
      ADDR_DUTY:       readdata[7:0]       = duty_q;
      ADDR_BLINK_MASK: readdata[LED_W-1:0] = blink_mask_q;
      default:         readdata[15:0]      = blink_div_q;
    endcase
  end

  assign pwm_on = (duty_act_q == PWM_FULL) || (pwm_cnt < duty_act_q);

  for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
    assign led_out_d[gi] = ctrl_q[CTRL_INV_BIT] ^
                           (ctrl_q[CTRL_EN_BIT] & led_q[gi] & pwm_on &
                            (~blink_mask_q[gi] | blink_phase));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q       <= CTRL_RESET;
      duty_q       <= DUTY_RESET;
      duty_act_q   <= DUTY_RESET;
      blink_mask_q <= '0;
      blink_div_q  <= BLINK_DIV_RESET;
      led_q        <= '0;
      led_out_q    <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      duty_q       <= duty_d;
      duty_act_q   <= duty_act_d;
      blink_mask_q <= blink_mask_d;
      blink_div_q  <= blink_div_d;
      led_q        <= led_in;
      led_out_q    <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_nios_sys_led_driver.sv
// Directed bench for nios_sys_led_driver with PRESCALE_DIV=4 (1024 clk per frame);
// expected pin values are worked out by hand from frame/tick positions.
module tb_nios_sys_led_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_in;
  logic [7:0]  led_out;

  int tests  = 0;
  int failed = 0;
  int cyc;

  nios_sys_led_driver #(
    .PRESCALE_DIV (4),
    .LED_W        (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_in     (led_in),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; at the negedge after edge m, cyc == m
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
    if (cyc != t) begin
      tests++;
      failed++;
      $error("FAIL sync observed=%0d expected=%0d", cyc, t);
    end
  endtask

  task automatic led_at(input int t, input string tag, input logic [7:0] exp);
    wait_cyc(t);
    check(tag, {24'd0, led_out}, {24'd0, exp});
  endtask

  task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("[TB] write addr=%0d data=%h cyc=%0d", a, d, cyc);
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    led_in     = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_led_out", {24'd0, led_out}, 32'h0);
    reset_n = 1'b1;

    // Pass-through: exactly two clocks
    led_in = 8'hA5;
    led_at(1, "pass_1clk", 8'h00);
    led_at(2, "pass_2clk", 8'hA5);
    rd(2'd0, "rst_ctrl", 32'h1);
    rd(2'd1, "rst_duty", 32'hFF);
    rd(2'd2, "rst_mask", 32'h0);
    rd(2'd3, "rst_bdiv", 32'h0);

    // PWM 0x40: active from the frame starting at state 1024
    avm_write(2'd1, 32'h40);
    led_in = 8'hFF;
    led_at(1024, "duty40_pre_frame", 8'hFF);
    led_at(1025, "duty40_first_on", 8'hFF);
    led_at(1280, "duty40_last_on", 8'hFF);
    led_at(1281, "duty40_first_off", 8'h00);
    rd(2'd1, "duty_rb_40", 32'h40);

    // Shadowed update to 0x80 mid-frame
    avm_write(2'd1, 32'h80);
    rd(2'd1, "duty_rb_80", 32'h80);
    led_at(1400, "shadow_keep_40", 8'h00);
    led_at(2048, "shadow_frame_end", 8'h00);
    led_at(2049, "duty80_first_on", 8'hFF);
    led_at(2560, "duty80_last_on", 8'hFF);
    led_at(2561, "duty80_first_off", 8'h00);

    // Duty zero: always off
    avm_write(2'd1, 32'h00);
    led_at(3073, "duty00_start", 8'h00);
    led_at(3500, "duty00_mid", 8'h00);

    // Blink: mask 0x0F, two frames per half period
    avm_write(2'd1, 32'hFF);
    avm_write(2'd2, 32'h0F);
    avm_write(2'd3, 32'h2);
    led_at(4096, "blink_duty0_tail", 8'h00);
    led_at(4097, "blink_phase1_a", 8'hFF);
    led_at(5120, "blink_phase1_b", 8'hFF);
    led_at(5121, "blink_phase0_a", 8'hF0);
    led_at(7168, "blink_phase0_b", 8'hF0);
    led_at(7169, "blink_phase1_c", 8'hFF);
    led_at(9217, "blink_phase0_c", 8'hF0);
    wait_cyc(9300);
    avm_write(2'd3, 32'h0);
    check("bdiv0_same_cycle", {24'd0, led_out}, 32'hF0);
    led_at(9302, "bdiv0_steady_a", 8'hFF);
    led_at(10300, "bdiv0_steady_b", 8'hFF);
    rd(2'd2, "mask_rb", 32'h0F);
    rd(2'd3, "bdiv_rb", 32'h0);

    // CTRL enable/invert
    led_in = 8'h0F;
    avm_write(2'd0, 32'h3);
    check("ctrl3_1clk", {24'd0, led_out}, 32'hFF);
    led_at(10302, "ctrl3_inv", 8'hF0);
    avm_write(2'd0, 32'h2);
    check("ctrl2_1clk", {24'd0, led_out}, 32'hF0);
    led_at(10304, "ctrl2_off_inv", 8'hFF);
    avm_write(2'd0, 32'h0);
    check("ctrl0_1clk", {24'd0, led_out}, 32'hFF);
    led_at(10306, "ctrl0_off", 8'h00);
    rd(2'd0, "ctrl_rb", 32'h0);

    // Async reset mid-blink, mid-frame
    led_in = 8'hFF;
    avm_write(2'd0, 32'h1);
    avm_write(2'd3, 32'h1);
    led_at(10700, "pre_reset_on", 8'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_led", {24'd0, led_out}, 32'h0);
    rd(2'd1, "reset_duty_rb", 32'hFF);
    rd(2'd3, "reset_bdiv_rb", 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Counters restart at 0: duty 0x01 is on only for pwm_cnt 0 of the next frame
    avm_write(2'd2, 32'h0F);
    check("post_reset_ledq", {24'd0, led_out}, 32'h00);
    avm_write(2'd1, 32'h01);
    led_at(3, "post_reset_phase1", 8'hFF);
    led_at(1024, "post_reset_pre_frame", 8'hFF);
    led_at(1028, "post_reset_duty1_on", 8'hFF);
    led_at(1029, "post_reset_duty1_off", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/nios_sys_led_driver.md
Name: nios_sys_led_driver

Overview:
Downstream stage for the 8-bit LED PIO. It consumes the PIO's out_port bits and drives the physical LED pins. It adds global PWM dimming, per-LED blinking, output enable and polarity inversion, all configured over a small Avalon-MM slave. Reset configuration is a transparent pass-through with 2-cycle latency, so the block can be dropped in behind the PIO with no software change.

Parameters:
PRESCALE_DIV, 196, clk cycles per PWM tick (range 1..65535); 50 MHz/196/256 gives a frame rate of about 1 kHz.
LED_W, 8, number of LED channels; must match the PIO width.

Ports:
clk  in  1  system clock
reset_n  in  1  reset
address  in  2  Avalon-MM register select
chipselect  in  1  Avalon-MM chip select
write_n  in  1  Avalon-MM write strobe, active-low
writedata  in  32  Avalon-MM write data
readdata  out  32  Avalon-MM read data, combinational, zero wait states
led_in  in  LED_W  LED pattern from PIO out_port
led_out  out  LED_W  registered drive to LED pins

Behaviour:
- Clock and reset: clk is the clock; reset_n is asynchronous, active-low. All flops clear on reset_n low.
- Reset values:
  - led_out=0, led_q=0.
  - CTRL=0x1 (enabled, not inverted).
  - DUTY and duty_act = 0xFF.
  - BLINK_MASK=0, BLINK_DIV=0.
  - Prescaler=0, pwm_cnt=0, blink_cnt=0, blink_phase=1.
- Register map (write = chipselect & ~write_n; unused bits write-ignored, read 0):
  - addr0 CTRL: bit0 EN, bit1 INV.
  - addr1 DUTY[7:0]: pending duty. Reads return the last written value, not the active one.
  - addr2 BLINK_MASK[LED_W-1:0].
  - addr3 BLINK_DIV[15:0]: blink half-period in PWM frames.
- Read path: readdata is a combinational mux of the selected register, zero-extended. It is independent of chipselect.
- Input stage: led_q <= led_in every clk.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1 and wraps.
  - tick asserts for 1 clk when count == PRESCALE_DIV-1.
- PWM counter:
  - pwm_cnt (8-bit) increments on tick and wraps 255->0.
  - frame_end = tick & (pwm_cnt==255).
- Duty shadowing:
  - duty_act <= DUTY on frame_end only. This makes dimming glitch-free.
  - If a DUTY write coincides with frame_end, the newly written value is loaded.
- PWM on condition: pwm_on = (duty_act==0xFF) | (pwm_cnt < duty_act).
  - 0x00 gives always off.
  - 0xFF gives always on (special case).
  - Otherwise high for duty_act ticks of each 256-tick frame.
- Blink:
  - On frame_end, when BLINK_DIV != 0: if blink_cnt == BLINK_DIV-1, set blink_cnt=0 and toggle blink_phase; else blink_cnt++.
  - When BLINK_DIV == 0: blink_phase is forced to 1 and blink_cnt is held at 0.
  - Any write to BLINK_DIV clears blink_cnt and sets blink_phase=1 on the next edge. The write has priority over a simultaneous frame_end.
- Output:
  - led_out[i] <= INV ^ (EN & led_q[i] & pwm_on & (~BLINK_MASK[i] | blink_phase)).
  - EN=0 forces a logical off; the pin then reads INV.
- Latency:
  - led_in to led_out is 2 clk.
  - CTRL and BLINK_MASK writes are visible at led_out 2 clk after the write cycle (register, then output flop).
  - DUTY writes take effect from the first frame after the next frame_end.
- Reset mid-operation: all counters and the shadow return to reset values immediately. led_out goes to 0 asynchronously.

Decomposition:
- Shared package: register address constants (CTRL=0, DUTY=1, BLINK_MASK=2, BLINK_DIV=3), CTRL bit indices, PWM_FULL=8'hFF, and reset defaults.
- One natural sub-module: nios_sys_led_timebase. It contains the prescaler, pwm_cnt and blink counter/phase, and outputs tick, pwm_cnt, frame_end and blink_phase.
- The top level holds the Avalon register file, the duty shadow and the output logic.

Test Plan:
- Reset pass-through: PRESCALE_DIV=4, after reset drive led_in=0xA5 -> led_out=0xA5 exactly 2 clk later; readdata at addr0=0x1, addr1=0xFF.
- PWM duty: write DUTY=0x40, led_in=0xFF -> after the next frame_end, led_out=0xFF for 64 ticks (256 clk) and 0x00 for 192 ticks per frame. DUTY=0x00 gives a constant 0x00.
- Shadowed duty: write DUTY=0x80 mid-frame while duty_act=0x40 -> the rest of the frame keeps 64-tick high time; the new 128-tick high time starts only after frame_end. Readback of addr1 gives 0x80 immediately.
- Blink: BLINK_MASK=0x0F, BLINK_DIV=2, DUTY=0xFF, led_in=0xFF -> led_out alternates 0xFF and 0xF0 every 2 frames. A write of BLINK_DIV=0 gives a steady 0xFF.
- CTRL: write CTRL=0x3 with led_in=0x0F -> led_out=0xF0 after 2 clk; write CTRL=0x2 -> led_out=0xFF; write CTRL=0x0 -> 0x00.
- Async reset mid-blink and mid-frame: assert reset_n low between edges -> led_out=0 immediately. After release: counters restart from 0, blink_phase=1, DUTY readback 0xFF.
